// File: rtl/rs_queue.sv
// Reservation station: buffers renamed micro-ops and issues the oldest ready one per cycle.
// Optional writeback bypass of operand readiness is enabled by defining RS_QUEUE_WB_BYPASS_EN.
package rs_queue_pkg;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned ROB_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          pc;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [1:0]           fu;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [31:0]          imm;
  } rename_data;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [ROB_TAG_W-1:0] rob_index;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [1:0]           fu;
    logic [PREG_W-1:0]    pd;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [31:0]          imm;
  } rs_data;
endpackage

module rs_queue
  import rs_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_PREG = 128,
  parameter int unsigned ROB_W    = 5,
  parameter int unsigned AFULL_TH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  rename_data               r_data,
  input  logic                     di_en,
  input  logic [0:NUM_PREG-1]      preg_rtable,
  input  logic                     fu_ready,
  input  logic [ROB_W-1:0]         rob_head,
  input  logic [ROB_W-1:0]         rob_index_in,
  input  logic                     mispredict,
  input  logic [ROB_W-1:0]         mispredict_tag,
`ifdef RS_QUEUE_WB_BYPASS_EN
  input  logic                     wb_valid,
  input  logic [$clog2(NUM_PREG)-1:0] wb_pd,
`endif
  output logic                     fu_issued,
  output rs_data                   data_out,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dispatch_drop
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  // Struct field widths come from the package; these parameters must agree with it.
  rs_data entries_q [DEPTH];
  rs_data entries_d [DEPTH];
  rs_data data_out_q, data_out_d;
  logic   fu_issued_q, fu_issued_d;
  logic   drop_q, drop_d;

  logic [DEPTH-1:0] s1_ok, s2_ok, ready, flush_hit;
  logic [ROB_W-1:0] age [DEPTH];
  logic [ROB_W-1:0] best_age, flush_len, flush_off;
  logic [IDX_W-1:0] sel_idx, free_idx, tgt_idx;
  logic             any_ready, has_free, issue;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      free_slots;
  rs_data           new_entry;

  function automatic logic needs_ps1(input logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction

  function automatic logic needs_ps2(input logic [6:0] op);
    return (op == 7'h33 || op == 7'h23 || op == 7'h63);
  endfunction

  always_comb begin
    s1_ok     = '0;
    s2_ok     = '0;
    ready     = '0;
    flush_hit = '0;
    flush_len = rob_index_in - mispredict_tag - ROB_W'(1);
    flush_off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef RS_QUEUE_WB_BYPASS_EN
      s1_ok[i] = preg_rtable[entries_q[i].ps1] | (wb_valid & (wb_pd == entries_q[i].ps1));
      s2_ok[i] = preg_rtable[entries_q[i].ps2] | (wb_valid & (wb_pd == entries_q[i].ps2));
`else
      s1_ok[i] = preg_rtable[entries_q[i].ps1];
      s2_ok[i] = preg_rtable[entries_q[i].ps2];
`endif
      ready[i] = entries_q[i].valid
               & (s1_ok[i] | ~needs_ps1(entries_q[i].Opcode))
               & (s2_ok[i] | ~needs_ps2(entries_q[i].Opcode));
      age[i]   = entries_q[i].rob_index - rob_head;
      // Offset past the branch tag; the wrong path is the first flush_len tags after it.
      flush_off    = entries_q[i].rob_index - mispredict_tag - ROB_W'(1);
      flush_hit[i] = entries_q[i].valid & (flush_off < flush_len);
    end
  end

  always_comb begin
    any_ready = 1'b0;
    best_age  = '1;
    sel_idx   = '0;
    has_free  = 1'b0;
    free_idx  = '0;
    cnt       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!any_ready || age[i] < best_age)) begin
        any_ready = 1'b1;
        best_age  = age[i];
        sel_idx   = IDX_W'(i);
      end
      if (!entries_q[i].valid && !has_free) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      cnt = cnt + CNT_W'(entries_q[i].valid);
    end
  end

  assign issue   = any_ready & fu_ready & ~mispredict;
  assign tgt_idx = has_free ? free_idx : sel_idx;

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.pc        = r_data.pc;
    new_entry.rob_index = r_data.rob_tag;
    new_entry.Opcode    = r_data.Opcode;
    new_entry.func3     = r_data.func3;
    new_entry.func7     = r_data.func7;
    new_entry.fu        = r_data.fu;
    new_entry.pd        = r_data.pd_new;
    new_entry.ps1       = r_data.ps1;
    new_entry.ps2       = r_data.ps2;
    new_entry.imm       = r_data.imm;
  end

  always_comb begin
    entries_d   = entries_q;
    data_out_d  = data_out_q;
    fu_issued_d = 1'b0;
    drop_d      = 1'b0;
    if (mispredict) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (flush_hit[i]) entries_d[i] = '0;
      end
    end else begin
      if (issue) begin
        entries_d[sel_idx] = '0;
        data_out_d         = entries_q[sel_idx];
        fu_issued_d        = 1'b1;
      end
      // Written after the issue clear so a full table reuses the issuing slot.
      if (di_en) begin
        if (has_free || issue) entries_d[tgt_idx] = new_entry;
        else                   drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      data_out_q  <= '0;
      fu_issued_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      data_out_q  <= data_out_d;
      fu_issued_q <= fu_issued_d;
      drop_q      <= drop_d;
    end
  end

  assign free_slots    = 32'(DEPTH) - 32'(cnt);
  assign count         = cnt;
  assign full          = (cnt == CNT_W'(DEPTH));
  assign almost_full   = (free_slots <= 32'(AFULL_TH));
  assign data_out      = data_out_q;
  assign fu_issued     = fu_issued_q;
  assign dispatch_drop = drop_q;

endmodule

// File: tb/tb_rs_queue.sv
// Directed self-checking bench for rs_queue with hand-computed expectations.
module tb_rs_queue;
  import rs_queue_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  rename_data       r_data;
  logic             di_en;
  logic [0:127]     prt;
  logic             fu_ready;
  logic [4:0]       rob_head, rob_index_in, mispredict_tag;
  logic             mispredict;
  logic             fu_issued, full, almost_full, dispatch_drop;
  rs_data           data_out;
  logic [3:0]       count;
`ifdef RS_QUEUE_WB_BYPASS_EN
  logic             wb_valid;
  logic [6:0]       wb_pd;
`endif

  int checks = 0;
  int errors = 0;

  rs_queue #(.DEPTH(8), .NUM_PREG(128), .ROB_W(5), .AFULL_TH(2)) dut (
    .clk(clk), .reset(reset), .r_data(r_data), .di_en(di_en), .preg_rtable(prt),
    .fu_ready(fu_ready), .rob_head(rob_head), .rob_index_in(rob_index_in),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
`ifdef RS_QUEUE_WB_BYPASS_EN
    .wb_valid(wb_valid), .wb_pd(wb_pd),
`endif
    .fu_issued(fu_issued), .data_out(data_out), .full(full), .almost_full(almost_full),
    .count(count), .dispatch_drop(dispatch_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] tag, input logic [6:0] op,
                        input logic [6:0] p1, input logic [6:0] p2);
    r_data         = '0;
    r_data.pc      = 32'h1000 + 32'(tag) * 4;
    r_data.rob_tag = tag;
    r_data.Opcode  = op;
    r_data.ps1     = p1;
    r_data.ps2     = p2;
    r_data.pd_new  = 7'(tag);
    r_data.imm     = 32'hABC0 + 32'(tag);
  endtask

  task automatic disp(input logic [4:0] tag, input logic [6:0] op,
                      input logic [6:0] p1, input logic [6:0] p2);
    set_op(tag, op, p1, p2);
    di_en = 1'b1;
    tick();
    di_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; di_en = 1'b0; prt = '0; fu_ready = 1'b0; rob_head = '0;
    rob_index_in = '0; mispredict = 1'b0; mispredict_tag = '0; r_data = '0;
`ifdef RS_QUEUE_WB_BYPASS_EN
    wb_valid = 1'b0; wb_pd = '0;
`endif
    tick(); tick();
    reset = 1'b0;
    check("rst_count", 64'(count), 0);
    check("rst_full", 64'(full), 0);
    check("rst_afull", 64'(almost_full), 0);
    check("rst_issued", 64'(fu_issued), 0);
    check("rst_drop", 64'(dispatch_drop), 0);
    check("rst_dout", 64'(data_out.rob_index), 0);

    // Oldest first across ROB wrap
    prt[1] = 1'b1; prt[2] = 1'b1; rob_head = 5'd30;
    disp(5'd1, 7'h33, 7'd1, 7'd2);
    disp(5'd31, 7'h33, 7'd1, 7'd2);
    disp(5'd0, 7'h33, 7'd1, 7'd2);
    check("old_count", 64'(count), 3);
    fu_ready = 1'b1;
    tick(); check("old_v0", 64'(fu_issued), 1); check("old_t0", 64'(data_out.rob_index), 31);
    tick(); check("old_t1", 64'(data_out.rob_index), 0);
    tick(); check("old_t2", 64'(data_out.rob_index), 1);
    check("old_pc", 64'(data_out.pc), 64'h1004);
    tick(); check("old_idle", 64'(fu_issued), 0);
    check("old_hold", 64'(data_out.rob_index), 1);
    check("old_empty", 64'(count), 0);
    fu_ready = 1'b0;

    // Fill, overflow, then slot reuse
    do_reset();
    rob_head = '0;
    for (int i = 0; i < 8; i++) begin
      disp(5'(i), 7'h33, 7'(20 + i), 7'(40 + i));
      if (i == 4) check("afull_at5", 64'(almost_full), 0);
      if (i == 5) check("afull_at6", 64'(almost_full), 1);
    end
    check("fill_full", 64'(full), 1);
    check("fill_count", 64'(count), 8);
    disp(5'd8, 7'h33, 7'd28, 7'd48);
    check("ovf_drop", 64'(dispatch_drop), 1);
    check("ovf_count", 64'(count), 8);
    check("ovf_issued", 64'(fu_issued), 0);
    tick();
    check("ovf_drop_end", 64'(dispatch_drop), 0);
    prt[23] = 1'b1; prt[43] = 1'b1; fu_ready = 1'b1;
    disp(5'd8, 7'h33, 7'd28, 7'd48);
    fu_ready = 1'b0;
    check("reuse_issued", 64'(fu_issued), 1);
    check("reuse_tag", 64'(data_out.rob_index), 3);
    check("reuse_count", 64'(count), 8);
    check("reuse_drop", 64'(dispatch_drop), 0);
    prt[28] = 1'b1; prt[48] = 1'b1; fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    check("reuse_new_tag", 64'(data_out.rob_index), 8);
    check("reuse_new_pc", 64'(data_out.pc), 64'h1020);
    check("reuse_after", 64'(count), 7);

    // Flush across ROB wrap
    do_reset();
    rob_head = 5'd29;
    disp(5'd29, 7'h33, 7'd60, 7'd61);
    disp(5'd30, 7'h33, 7'd60, 7'd61);
    disp(5'd31, 7'h33, 7'd60, 7'd61);
    disp(5'd0, 7'h33, 7'd60, 7'd61);
    disp(5'd2, 7'h33, 7'd60, 7'd61);
    check("fl_pre", 64'(count), 5);
    prt[60] = 1'b1; prt[61] = 1'b1; fu_ready = 1'b1;
    set_op(5'd3, 7'h37, 7'd0, 7'd0); di_en = 1'b1;
    mispredict = 1'b1; mispredict_tag = 5'd30; rob_index_in = 5'd1;
    tick();
    mispredict = 1'b0; di_en = 1'b0;
    check("fl_count", 64'(count), 3);
    check("fl_noissue", 64'(fu_issued), 0);
    check("fl_nodrop", 64'(dispatch_drop), 0);
    tick(); check("fl_i0", 64'(data_out.rob_index), 29);
    tick(); check("fl_i1", 64'(data_out.rob_index), 30);
    tick(); check("fl_i2", 64'(data_out.rob_index), 2);
    check("fl_empty", 64'(count), 0);
    fu_ready = 1'b0;

    // Operand needs and wakeup
    rob_head = '0; prt[3] = 1'b1;
    disp(5'd5, 7'h37, 7'd70, 7'd70);
    disp(5'd6, 7'h13, 7'd3, 7'd70);
    disp(5'd7, 7'h23, 7'd3, 7'd71);
    fu_ready = 1'b1;
    tick(); check("need_lui", 64'(data_out.rob_index), 5);
    tick(); check("need_addi", 64'(data_out.rob_index), 6);
    tick(); check("need_sw_wait", 64'(fu_issued), 0);
    check("need_sw_count", 64'(count), 1);
    prt[71] = 1'b1;
    tick(); check("need_sw_go", 64'(fu_issued), 1);
    check("need_sw_tag", 64'(data_out.rob_index), 7);
    check("need_sw_imm", 64'(data_out.imm), 64'hABC7);
    disp(5'd9, 7'h37, 7'd0, 7'd0);
    check("lat_none", 64'(fu_issued), 0);
    check("lat_count", 64'(count), 1);
    tick(); check("lat_issue", 64'(data_out.rob_index), 9);
    check("lat_pulse", 64'(fu_issued), 1);
    fu_ready = 1'b0;

    // Adjacent tags: empty flush window
    for (int i = 0; i < 5; i++) disp(5'(i), 7'h33, 7'd100, 7'd101);
    mispredict = 1'b1; mispredict_tag = 5'd10; rob_index_in = 5'd11;
    tick();
    mispredict = 1'b0;
    check("fl_none", 64'(count), 5);

    // Reset mid-operation with dispatch and issue requested
    prt[100] = 1'b1; prt[101] = 1'b1; fu_ready = 1'b1;
    set_op(5'd5, 7'h37, 7'd0, 7'd0); di_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_count", 64'(count), 0);
    check("mrst_issued", 64'(fu_issued), 0);
    check("mrst_dout", 64'(data_out.pc), 0);
    tick();
    di_en = 1'b0;
    check("mrst_redisp", 64'(count), 1);
    tick(); check("mrst_issue", 64'(data_out.rob_index), 5);
    fu_ready = 1'b0;

`ifdef RS_QUEUE_WB_BYPASS_EN
    do_reset();
    fu_ready = 1'b1;
    disp(5'd12, 7'h33, 7'd90, 7'd3);
    check("byp_wait", 64'(fu_issued), 0);
    wb_valid = 1'b1; wb_pd = 7'd90;
    tick();
    wb_valid = 1'b0;
    check("byp_issue", 64'(fu_issued), 1);
    check("byp_tag", 64'(data_out.rob_index), 12);
    fu_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
